// File: rtl/sprite_plotter_pkg.sv
// Shared constants and types for the sprite plotter:
// screen geometry, sprite sizes, colours and FSM states.
package sprite_plotter_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [7:0] BIRD_X  = 8'd40;
  localparam logic [3:0] BIRD_SZ = 4'd4;
  localparam logic [3:0] WALL_W  = 4'd8;
  localparam logic [6:0] GAP_H   = 7'd32;

  localparam logic [2:0] COL_BIRD = 3'b110;
  localparam logic [2:0] COL_WALL = 3'b010;
  localparam logic [2:0] COL_BG   = 3'b000;

  localparam logic OBJ_WALL = 1'b0;
  localparam logic OBJ_BIRD = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/sprite_plotter_scanner.sv
// Row-major offset generator for a w x h rectangle.
// nxt_dx/nxt_dy expose the following offset one cycle early.
module rect_scanner (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  input  logic [3:0] w,
  input  logic [6:0] h,
  output logic [3:0] dx,
  output logic [6:0] dy,
  output logic [3:0] nxt_dx,
  output logic [6:0] nxt_dy,
  output logic       last
);

  logic col_end;

  assign col_end = (dx == w - 4'd1);
  assign last    = col_end && (dy == h - 7'd1);

  always_comb begin
    nxt_dx = dx + 4'd1;
    nxt_dy = dy;
    if (col_end) begin
      nxt_dx = 4'd0;
      nxt_dy = dy + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      dx <= 4'd0;
      dy <= 7'd0;
    end else if (step) begin
      dx <= nxt_dx;
      dy <= nxt_dy;
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Scans a bird or wall rectangle into VGA pixel writes,
// one pixel per cycle, with clipping and gap clearing.
module sprite_plotter
  import sprite_plotter_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       obj_sel,
  input  logic       erase,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t state_q, state_d;

  logic       obj_q, erase_q;
  logic [6:0] by_q, gy_q;
  logic [7:0] wx_q;

  logic [3:0] dx, nxt_dx, w;
  logic [6:0] dy, nxt_dy, h;
  logic       last, accept, load;

  logic       s_obj, s_erase;
  logic [6:0] s_by, s_gy;
  logic [7:0] s_wx;
  logic [3:0] o_dx;
  logic [6:0] o_dy;
  logic [8:0] px, gap_hi;
  logic [7:0] py;
  logic [2:0] col;
  logic       on_scr, in_gap;

  assign w = (obj_q == OBJ_BIRD) ? BIRD_SZ : WALL_W;
  assign h = (obj_q == OBJ_BIRD) ? 7'(BIRD_SZ) : 7'(SCREEN_H);

  rect_scanner u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q != SCAN),
    .step   (state_q == SCAN && !last),
    .w      (w),
    .h      (h),
    .dx     (dx),
    .dy     (dy),
    .nxt_dx (nxt_dx),
    .nxt_dy (nxt_dy),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign accept = (state_q == IDLE) && start;
  assign load   = accept || (state_q == SCAN && !last);

  // Pixel 0 is built from the live inputs on the accepting edge,
  // later pixels from the latched copy and the next offset.
  always_comb begin
    s_obj   = obj_q;
    s_erase = erase_q;
    s_by    = by_q;
    s_wx    = wx_q;
    s_gy    = gy_q;
    o_dx    = nxt_dx;
    o_dy    = nxt_dy;
    if (state_q == IDLE) begin
      s_obj   = obj_sel;
      s_erase = erase;
      s_by    = bird_y;
      s_wx    = wall_x;
      s_gy    = gap_y;
      o_dx    = 4'd0;
      o_dy    = 7'd0;
    end
  end

  always_comb begin
    px = (s_obj == OBJ_BIRD) ? {1'b0, BIRD_X} : {1'b0, s_wx};
    py = (s_obj == OBJ_BIRD) ? {1'b0, s_by} : 8'd0;
    px = px + 9'(o_dx);
    py = py + 8'(o_dy);
    on_scr = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    gap_hi = 9'(s_gy) + 9'(GAP_H);
    in_gap = (py >= {1'b0, s_gy}) && ({1'b0, py} < gap_hi);
    col = COL_WALL;
    if (s_erase)               col = COL_BG;
    else if (s_obj == OBJ_BIRD) col = COL_BIRD;
    else if (in_gap)           col = COL_BG;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x       <= 8'd0;
      y       <= 7'd0;
      colour  <= 3'd0;
      plot    <= 1'b0;
      obj_q   <= 1'b0;
      erase_q <= 1'b0;
      by_q    <= 7'd0;
      wx_q    <= 8'd0;
      gy_q    <= 7'd0;
    end else begin
      plot <= 1'b0;
      if (load) begin
        x      <= px[7:0];
        y      <= py[6:0];
        colour <= col;
        plot   <= on_scr;
      end
      if (accept) begin
        obj_q   <= obj_sel;
        erase_q <= erase;
        by_q    <= bird_y;
        wx_q    <= wall_x;
        gy_q    <= gap_y;
      end
    end
  end

  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: expected pixels are queued
// at each draw request and popped by a monitor on busy cycles.
module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       resetn, start, obj_sel, erase;
  logic [6:0] bird_y, gap_y;
  logic [7:0] wall_x;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  pix_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int pix_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  sprite_plotter dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .obj_sel(obj_sel),
    .erase  (erase),
    .bird_y (bird_y),
    .wall_x (wall_x),
    .gap_y  (gap_y),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_pixel: got x=%0d y=%0d c=%0d p=%0b, none expected",
                 x, y, colour, plot);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if (x !== e.x || y !== e.y || colour !== e.c || plot !== e.p) begin
          n_fail++;
          $display("FAIL pixel %0d: got x=%0d y=%0d c=%0d p=%0b, want x=%0d y=%0d c=%0d p=%0b",
                   pix_cnt, x, y, colour, plot, e.x, e.y, e.c, e.p);
        end
      end
      pix_cnt++;
      busy_cnt++;
    end else if (resetn) begin
      n_chk++;
      if (plot !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_plot: got %0b, want 0", plot);
      end
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push_obj(input bit obj, input bit er, input int by,
                          input int wx, input int gy);
    int ox, oy, w, h, xf, yf;
    pix_t e;
    if (obj) begin
      ox = 40; oy = by; w = 4; h = 4;
    end else begin
      ox = wx; oy = 0; w = 8; h = 120;
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        xf = ox + c;
        yf = oy + r;
        e.x = xf[7:0];
        e.y = yf[6:0];
        e.p = (xf < 160) && (yf < 120);
        if (er) e.c = 3'b000;
        else if (obj) e.c = 3'b110;
        else if (yf >= gy && yf < gy + 32) e.c = 3'b000;
        else e.c = 3'b010;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic issue(input bit obj, input bit er, input int by,
                       input int wx, input int gy);
    obj_sel = obj;
    erase   = er;
    bird_y  = 7'(by);
    wall_x  = 8'(wx);
    gap_y   = 7'(gy);
    push_obj(obj, er, by, wx, gy);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle 1 is the first one after the accepting edge.
  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (!done && cyc < max) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles", max);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string nm, input bit obj, input bit er,
                     input int by, input int wx, input int gy,
                     input int n_pix);
    int b0, d0, cyc;
    b0 = busy_cnt;
    d0 = done_cnt;
    issue(obj, er, by, wx, gy);
    wait_done(n_pix + 50, cyc);
    chk({nm, "_done_cycle"}, cyc, n_pix + 1);
    chk({nm, "_busy_cycles"}, busy_cnt - b0, n_pix);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int b0, d0, p0, n;
    resetn = 1'b0;
    start = 1'b0;
    obj_sel = 1'b0;
    erase = 1'b0;
    bird_y = 7'd0;
    wall_x = 8'd0;
    gap_y = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run("bird50", 1'b1, 1'b0, 50, 0, 0, 16);
    chk("hold_x", x, 43);
    chk("hold_y", y, 53);
    chk("hold_colour", colour, 3'b110);

    run("wall100", 1'b0, 1'b0, 0, 100, 40, 960);
    run("wall156", 1'b0, 1'b0, 0, 156, 100, 960);

    // start re-pulsed mid-scan with new inputs must be ignored
    b0 = busy_cnt;
    d0 = done_cnt;
    issue(1'b1, 1'b0, 60, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    bird_y = 7'd10;
    obj_sel = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("repulse_busy", busy_cnt - b0, 16);
    chk("repulse_done", done_cnt - d0, 1);
    chk("repulse_queue", exp_q.size(), 0);

    // reset at wall pixel 300, with start also held high
    d0 = done_cnt;
    p0 = pix_cnt;
    issue(1'b0, 1'b0, 0, 20, 0);
    n = 0;
    while (pix_cnt - p0 < 300 && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("abort_at_pixel", pix_cnt - p0, 300);
    resetn = 1'b0;
    start = 1'b1;
    obj_sel = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_plot", plot, 0);
    chk("abort_x", x, 0);
    exp_q.delete();
    start = 1'b0;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);

    run("erase118", 1'b1, 1'b1, 118, 0, 0, 16);
    run("bird0", 1'b1, 1'b0, 0, 0, 0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
